// File: rtl/gomoku_turn_scheduler.sv
// ---------------------------------------------------------------------------
// gomoku_turn_scheduler
//
// Turn sequencer for the 11x11 Gomoku board. It owns the single board write
// port. On the human's turn it forwards an accepted cursor/enter press to the
// board. On the AI's turn it walks every cell, asks the evaluator to score
// each empty one, and writes the highest-scoring cell. It stops once the
// board-state block reports that the game is over.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   start          pulse: begin scheduling, or abort and restart at CHECK
//   ai_player      side the AI plays for
//   player         side to move, from the board-state block
//   game_status    00 = running, anything else = game over
//   human_write    debounced enter pulse
//   human_addr     cursor cell
//   occ_addr/occ   combinational occupancy lookup (occ valid same cycle)
//   eval_req/addr  registered evaluation request; address stable while high
//   eval_ack/score evaluator result, score signed, valid with eval_ack
//   wr_en/wr_addr  one-cycle board write strobe and its cell
//   busy           high in every state except IDLE and DONE
//   best_addr      last committed AI move
//   best_score     score of that move
//   no_move        sticky: an AI turn found no empty cell
// ---------------------------------------------------------------------------
module gomoku_turn_scheduler #(
    parameter int CELLS   = 121,
    parameter int ADDR_W  = 8,
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ai_player,
    input  logic               player,
    input  logic [1:0]         game_status,
    input  logic               human_write,
    input  logic [ADDR_W-1:0]  human_addr,
    output logic [ADDR_W-1:0]  occ_addr,
    input  logic               occ,
    output logic               eval_req,
    output logic [ADDR_W-1:0]  eval_addr,
    input  logic               eval_ack,
    input  logic [SCORE_W-1:0] eval_score,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               busy,
    output logic [ADDR_W-1:0]  best_addr,
    output logic [SCORE_W-1:0] best_score,
    output logic               no_move
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HUMAN,
        S_SCAN,
        S_EVAL_WAIT,
        S_COMMIT,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t                     state_reg, state_next;
    logic [ADDR_W-1:0]          scan_addr_reg, scan_addr_next;
    logic                       best_valid_reg, best_valid_next;
    logic [ADDR_W-1:0]          cand_addr_reg, cand_addr_next;
    logic signed [SCORE_W-1:0]  cand_score_reg, cand_score_next;
    logic                       latched_player_reg, latched_player_next;
    logic                       eval_req_reg, eval_req_next;
    logic [ADDR_W-1:0]          eval_addr_reg, eval_addr_next;
    logic                       wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]          wr_addr_reg, wr_addr_next;
    logic [ADDR_W-1:0]          best_addr_reg, best_addr_next;
    logic [SCORE_W-1:0]         best_score_reg, best_score_next;
    logic                       no_move_reg, no_move_next;

    logic game_over;
    assign game_over = (game_status != 2'b00);

    // Occupancy lookup follows whichever path currently owns the board view.
    assign occ_addr = (state_reg == S_HUMAN) ? human_addr : scan_addr_reg;

    assign busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign eval_req   = eval_req_reg;
    assign eval_addr  = eval_addr_reg;
    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign best_addr  = best_addr_reg;
    assign best_score = best_score_reg;
    assign no_move    = no_move_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= S_IDLE;
            scan_addr_reg      <= '0;
            best_valid_reg     <= 1'b0;
            cand_addr_reg      <= '0;
            cand_score_reg     <= '0;
            latched_player_reg <= 1'b0;
            eval_req_reg       <= 1'b0;
            eval_addr_reg      <= '0;
            wr_en_reg          <= 1'b0;
            wr_addr_reg        <= '0;
            best_addr_reg      <= '0;
            best_score_reg     <= '0;
            no_move_reg        <= 1'b0;
        end else begin
            state_reg          <= state_next;
            scan_addr_reg      <= scan_addr_next;
            best_valid_reg     <= best_valid_next;
            cand_addr_reg      <= cand_addr_next;
            cand_score_reg     <= cand_score_next;
            latched_player_reg <= latched_player_next;
            eval_req_reg       <= eval_req_next;
            eval_addr_reg      <= eval_addr_next;
            wr_en_reg          <= wr_en_next;
            wr_addr_reg        <= wr_addr_next;
            best_addr_reg      <= best_addr_next;
            best_score_reg     <= best_score_next;
            no_move_reg        <= no_move_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        scan_addr_next      = scan_addr_reg;
        best_valid_next     = best_valid_reg;
        cand_addr_next      = cand_addr_reg;
        cand_score_next     = cand_score_reg;
        latched_player_next = latched_player_reg;
        eval_req_next       = eval_req_reg;
        eval_addr_next      = eval_addr_reg;
        wr_en_next          = 1'b0;
        wr_addr_next        = wr_addr_reg;
        best_addr_next      = best_addr_reg;
        best_score_next     = best_score_reg;
        no_move_next        = no_move_reg;

        case (state_reg)
            S_IDLE: begin
                // Only start leaves IDLE; handled below.
            end

            S_CHECK: begin
                if (game_over) begin
                    state_next = S_DONE;
                end else if (player == ai_player) begin
                    state_next      = S_SCAN;
                    scan_addr_next  = '0;
                    best_valid_next = 1'b0;
                end else begin
                    state_next = S_HUMAN;
                end
            end

            S_HUMAN: begin
                // A finished game takes priority over a late enter press.
                if (game_over) begin
                    state_next = S_DONE;
                end else if (human_write && !occ) begin
                    wr_en_next          = 1'b1;
                    wr_addr_next        = human_addr;
                    latched_player_next = player;
                    state_next          = S_SETTLE;
                end
            end

            S_SCAN: begin
                if (!occ) begin
                    eval_req_next  = 1'b1;
                    eval_addr_next = scan_addr_reg;
                    state_next     = S_EVAL_WAIT;
                end else if (scan_addr_reg == LAST_CELL) begin
                    state_next = S_COMMIT;
                end else begin
                    scan_addr_next = scan_addr_reg + ADDR_ONE;
                end
            end

            S_EVAL_WAIT: begin
                if (eval_ack) begin
                    eval_req_next = 1'b0;
                    // Strictly greater: on a tie the earlier (lower) cell stays.
                    if (!best_valid_reg || ($signed(eval_score) > cand_score_reg)) begin
                        cand_addr_next  = eval_addr_reg;
                        cand_score_next = $signed(eval_score);
                        best_valid_next = 1'b1;
                    end
                    if (eval_addr_reg == LAST_CELL) begin
                        state_next = S_COMMIT;
                    end else begin
                        scan_addr_next = eval_addr_reg + ADDR_ONE;
                        state_next     = S_SCAN;
                    end
                end
            end

            S_COMMIT: begin
                if (best_valid_reg) begin
                    wr_en_next          = 1'b1;
                    wr_addr_next        = cand_addr_reg;
                    best_addr_next      = cand_addr_reg;
                    best_score_next     = cand_score_reg;
                    latched_player_next = player;
                    state_next          = S_SETTLE;
                end else begin
                    no_move_next = 1'b1;
                    state_next   = S_DONE;
                end
            end

            S_SETTLE: begin
                // Wait for the board to reflect the write before re-deciding.
                if ((player != latched_player_reg) || game_over) begin
                    state_next = S_CHECK;
                end
            end

            S_DONE: begin
                // Hold until start.
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // start from any state restarts at CHECK: any pending request is
        // dropped, the running candidate is forgotten, and a write decided in
        // this same cycle is cancelled so a turn never gets two writes.
        if (start) begin
            state_next      = S_CHECK;
            eval_req_next   = 1'b0;
            best_valid_next = 1'b0;
            wr_en_next      = 1'b0;
            wr_addr_next    = wr_addr_reg;
            no_move_next    = 1'b0;
        end
    end

endmodule

// File: tb/tb_gomoku_turn_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for gomoku_turn_scheduler. Models the board-state block (board
// occupancy, side to move flipping on each write) and the evaluator (score
// per cell by mode, configurable ack latency). Expected request and write
// addresses are queued when a scenario is set up and popped as the DUT emits
// them. A table of AI-turn scenarios is followed by hand-written sequences
// for human turns, full board, abandon/reset and game over in SETTLE.
// ---------------------------------------------------------------------------
module tb_gomoku_turn_scheduler;

    localparam int CELLS   = 121;
    localparam int ADDR_W  = 8;
    localparam int SCORE_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               ai_player = 1'b0;
    logic               player = 1'b0;
    logic [1:0]         game_status = 2'b00;
    logic               human_write = 1'b0;
    logic [ADDR_W-1:0]  human_addr = '0;
    logic [ADDR_W-1:0]  occ_addr;
    logic               occ;
    logic               eval_req;
    logic [ADDR_W-1:0]  eval_addr;
    logic               eval_ack = 1'b0;
    logic [SCORE_W-1:0] eval_score;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic               busy;
    logic [ADDR_W-1:0]  best_addr;
    logic [SCORE_W-1:0] best_score;
    logic               no_move;

    gomoku_turn_scheduler #(
        .CELLS  (CELLS),
        .ADDR_W (ADDR_W),
        .SCORE_W(SCORE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ai_player  (ai_player),
        .player     (player),
        .game_status(game_status),
        .human_write(human_write),
        .human_addr (human_addr),
        .occ_addr   (occ_addr),
        .occ        (occ),
        .eval_req   (eval_req),
        .eval_addr  (eval_addr),
        .eval_ack   (eval_ack),
        .eval_score (eval_score),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .best_addr  (best_addr),
        .best_score (best_score),
        .no_move    (no_move)
    );

    always #5 clk = ~clk;

    // Board model and evaluator model
    logic board [CELLS];
    int   cur_mode = 0;

    assign occ = (int'(occ_addr) < CELLS) ? board[int'(occ_addr)] : 1'b1;

    function automatic logic [15:0] score_of(input int mode, input logic [7:0] a);
        case (mode)
            0:       return (a == 8'd60) ? 16'h7FFF : {8'h00, a};
            1:       return 16'hFFFB;
            2:       return ((a == 8'd7) || (a == 8'd90)) ? 16'd100 : 16'hFFFF;
            default: return 16'(-(int'(a) + 1));
        endcase
    endfunction

    always_comb eval_score = score_of(cur_mode, eval_addr);

    // Scoreboard / bookkeeping
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_seen = 0;
    int wr_seen  = 0;
    int wr_cyc   = 0;
    int wait_cnt = 0;
    int ack_delay = 0;
    bit ack_tied  = 1'b0;
    bit auto_flip = 1'b1;
    bit prev_req  = 1'b0;
    bit prev_wr   = 1'b0;
    logic [7:0] cur_req = '0;
    logic [7:0] exp_req_q [$];
    logic [7:0] exp_wr_q  [$];

    typedef struct {
        int         pat;
        int         mode;
        bit         tied;
        int         delay;
        logic [7:0] exp_wr;
        logic [15:0] exp_score;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic flag(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got value %0d where none was expected", name, act);
    endtask

    // One clock: sample at the falling edge, score DUT activity, then update
    // the board/evaluator models for the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (eval_req && !prev_req) begin
            req_seen++;
            $display("[%0d] eval_req addr=%0d score=%0d", cyc, eval_addr, $signed(eval_score));
            if (exp_req_q.size() == 0) begin
                flag("unexpected_eval_req", int'(eval_addr));
            end else begin
                cur_req = exp_req_q.pop_front();
                check("eval_addr", int'(eval_addr), int'(cur_req));
            end
        end else if (eval_req) begin
            check("eval_addr_stable", int'(eval_addr), int'(cur_req));
        end
        if (wr_en) begin
            wr_seen++;
            wr_cyc = cyc;
            $display("[%0d] write addr=%0d best_addr=%0d best_score=%0d",
                     cyc, wr_addr, best_addr, $signed(best_score));
            if (prev_wr) flag("wr_en_width", int'(wr_addr));
            if (exp_wr_q.size() == 0) begin
                flag("unexpected_write", int'(wr_addr));
            end else begin
                check("wr_addr", int'(wr_addr), int'(exp_wr_q.pop_front()));
            end
            if (int'(wr_addr) < CELLS) board[int'(wr_addr)] = 1'b1;
            if (auto_flip) player = ~player;
        end
        prev_req = eval_req;
        prev_wr  = wr_en;
        if (ack_tied) begin
            eval_ack = 1'b1;
        end else if (eval_req) begin
            eval_ack = (wait_cnt == ack_delay);
            wait_cnt++;
        end else begin
            eval_ack = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic set_board(input int pat);
        for (int c = 0; c < CELLS; c++) begin
            case (pat)
                0:       board[c] = 1'b0;
                1:       board[c] = (c < 120);
                2:       board[c] = ((c % 2) == 1);
                3:       board[c] = (c < 10);
                default: board[c] = 1'b1;
            endcase
        end
    endtask

    task automatic do_reset();
        start       = 1'b0;
        human_write = 1'b0;
        game_status = 2'b00;
        rst         = 1'b1;
        exp_req_q.delete();
        exp_wr_q.delete();
        tick();
        tick();
        rst      = 1'b0;
        req_seen = 0;
        wr_seen  = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_eval_req"},   int'(eval_req),   0);
        check({tag, "_eval_addr"},  int'(eval_addr),  0);
        check({tag, "_wr_en"},      int'(wr_en),      0);
        check({tag, "_wr_addr"},    int'(wr_addr),    0);
        check({tag, "_busy"},       int'(busy),       0);
        check({tag, "_best_addr"},  int'(best_addr),  0);
        check({tag, "_best_score"}, int'(best_score), 0);
        check({tag, "_no_move"},    int'(no_move),    0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   exp_cyc;
        int   exp_reqs;
        int   s_cyc;
        v = vecs[idx];
        do_reset();
        set_board(v.pat);
        cur_mode  = v.mode;
        ack_tied  = v.tied;
        ack_delay = v.delay;
        auto_flip = 1'b1;
        ai_player = idx[0];
        player    = idx[0];
        exp_cyc   = 3;
        exp_reqs  = 0;
        for (int c = 0; c < CELLS; c++) begin
            if (board[c]) begin
                exp_cyc += 1;
            end else begin
                exp_cyc += 2 + (v.tied ? 0 : v.delay);
                exp_reqs++;
                exp_req_q.push_back(8'(c));
            end
        end
        exp_wr_q.push_back(v.exp_wr);
        s_cyc = cyc;
        pulse_start();
        for (int k = 0; k < 3000 && wr_seen == 0; k++) tick();
        check("vec_write_count", wr_seen, 1);
        check("vec_commit_cycle", wr_cyc - s_cyc, exp_cyc);
        check("vec_best_addr", int'(best_addr), int'(v.exp_wr));
        check("vec_best_score", int'(best_score), int'(v.exp_score));
        check("vec_no_move", int'(no_move), 0);
        check("vec_busy", int'(busy), 1);
        check("vec_req_count", req_seen, exp_reqs);
        check("vec_req_left", exp_req_q.size(), 0);
        $display("vec %0d: reqs=%0d write=%0d score=%0d cycles=%0d",
                 idx, req_seen, best_addr, $signed(best_score), wr_cyc - s_cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        int d;

        //        pat mode tied delay exp_wr exp_score
        vecs[0] = '{0, 0, 1'b1, 0, 8'd60,  16'h7FFF};
        vecs[1] = '{1, 1, 1'b0, 1, 8'd120, 16'hFFFB};
        vecs[2] = '{0, 2, 1'b0, 3, 8'd7,   16'd100};
        vecs[3] = '{2, 0, 1'b0, 2, 8'd60,  16'h7FFF};
        vecs[4] = '{3, 3, 1'b1, 0, 8'd10,  16'hFFF5};

        set_board(0);
        do_reset();
        check_reset_values("reset");

        for (int i = 0; i < 5; i++) run_vec(i);

        // Restart while an evaluation is outstanding, then reset mid-request.
        ack_tied  = 1'b0;
        ack_delay = 100000;
        for (int k = 0; k < 4; k++) tick();
        player = ai_player;
        r0 = req_seen;
        w0 = wr_seen;
        exp_req_q.push_back(8'd11);
        pulse_start();
        for (int k = 0; k < 50 && req_seen == r0; k++) tick();
        check("abandon_first_req", req_seen, r0 + 1);
        for (int k = 0; k < 3; k++) tick();
        check("eval_req_held", int'(eval_req), 1);
        pulse_start();
        check("eval_req_drop_on_start", int'(eval_req), 0);
        check("busy_after_restart", int'(busy), 1);
        exp_req_q.push_back(8'd11);
        for (int k = 0; k < 50 && req_seen == r0 + 1; k++) tick();
        check("restart_req", req_seen, r0 + 2);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check_reset_values("midreq_rst");
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("rst_over_start_idle", int'(busy), 0);
        check("no_write_after_rst", wr_seen, w0);

        // Human turn: occupied cell ignored, empty cell written next cycle.
        do_reset();
        set_board(0);
        board[5]  = 1'b1;
        ai_player = 1'b0;
        player    = 1'b1;
        auto_flip = 1'b1;
        pulse_start();
        for (int k = 0; k < 3; k++) tick();
        check("human_busy", int'(busy), 1);
        human_addr  = 8'd5;
        human_write = 1'b1;
        tick();
        human_write = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("human_occupied_dropped", wr_seen, 0);
        human_addr  = 8'd33;
        exp_wr_q.push_back(8'd33);
        human_write = 1'b1;
        d = cyc;
        tick();
        human_write = 1'b0;
        check("human_write_count", wr_seen, 1);
        check("human_write_latency", wr_cyc - d, 1);
        exp_req_q.push_back(8'd0);
        for (int k = 0; k < 20 && req_seen == 0; k++) tick();
        check("human_then_scan", req_seen, 1);

        // Full board on the AI turn.
        do_reset();
        set_board(4);
        ai_player = 1'b1;
        player    = 1'b1;
        pulse_start();
        for (int k = 0; k < 400 && busy; k++) tick();
        check("full_busy", int'(busy), 0);
        check("full_no_move", int'(no_move), 1);
        check("full_reqs", req_seen, 0);
        check("full_writes", wr_seen, 0);
        pulse_start();
        check("start_clears_no_move", int'(no_move), 0);
        check("start_from_done_busy", int'(busy), 1);
        for (int k = 0; k < 400 && busy; k++) tick();
        check("full_again_no_move", int'(no_move), 1);

        // Game over while settling after a human write.
        do_reset();
        set_board(0);
        ai_player = 1'b0;
        player    = 1'b1;
        auto_flip = 1'b0;
        pulse_start();
        for (int k = 0; k < 3; k++) tick();
        human_addr  = 8'd33;
        exp_wr_q.push_back(8'd33);
        human_write = 1'b1;
        tick();
        human_write = 1'b0;
        check("settle_write", wr_seen, 1);
        for (int k = 0; k < 3; k++) tick();
        check("settle_holds", int'(busy), 1);
        game_status = 2'b01;
        for (int k = 0; k < 10 && busy; k++) tick();
        check("gameover_busy", int'(busy), 0);
        for (int k = 0; k < 3; k++) tick();
        check("done_holds", int'(busy), 0);
        check("gameover_writes", wr_seen, 1);
        game_status = 2'b00;
        auto_flip   = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
